// File: rtl/scancode_digit_fifo.sv
// scancode_digit_fifo
//   Parses a PS/2 set-2 scancode byte stream and queues every decimal digit
//   make code (0..9) into a small first-in first-out buffer.
//   The parser follows the 0xE0 (extended) and 0xF0 (break) prefixes.
//   A held key's typematic repeats can optionally be suppressed.
//   Extended digit codes can optionally be accepted.
//
// Parameters
//   DEPTH       FIFO entries, power of two, 2..64
//   REPEAT_EN   1 = typematic repeats are pushed, 0 = repeats suppressed
//   ACCEPT_EXT  1 = digit codes after 0xE0 are decoded, 0 = dropped
//
// Ports
//   clk          single clock, rising edge
//   resetn       asynchronous active-low reset
//   code         scancode byte, sampled when code_valid is high
//   code_valid   qualifies code
//   dout         head-of-FIFO digit (0 while empty)
//   dout_valid   FIFO not empty
//   dout_ready   consumer accepts dout when dout_valid && dout_ready at an edge
//   level        current occupancy, 0..DEPTH
//   overflow     one-cycle pulse when a digit was dropped on a full FIFO
//   parse_state  debug view of the parser state (IDLE=0, EXT=1, BRK=2, EXT_BRK=3)
//
// Handshake: a pop happens on every rising edge where dout_valid and
// dout_ready are both high; dout_ready is ignored while the FIFO is empty,
// and there is no bypass from code to dout.
module scancode_digit_fifo #(
    parameter int DEPTH      = 8,
    parameter bit REPEAT_EN  = 1'b0,
    parameter bit ACCEPT_EXT = 1'b0
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [7:0]               code,
    input  logic                     code_valid,
    output logic [3:0]               dout,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [1:0]               parse_state
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LEVEL_FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [7:0]    last_make;
    logic          held;

    logic          is_make;
    logic          is_break;
    logic          is_ext;
    logic          is_digit;
    logic [3:0]    digit;
    logic          repeat_hit;
    logic          push;
    logic          pop;
    logic          full;
    logic          wr_en;

    logic [3:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // ---------------- parser ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        is_make    = 1'b0;
        is_break   = 1'b0;
        is_ext     = 1'b0;
        if (code_valid) begin
            case (state)
                IDLE: begin
                    if (code == 8'hF0)      state_next = BRK;
                    else if (code == 8'hE0) state_next = EXT;
                    else                    is_make = 1'b1;
                end
                EXT: begin
                    if (code == 8'hF0)      state_next = EXT_BRK;
                    else if (code == 8'hE0) state_next = EXT;
                    else begin
                        is_make    = 1'b1;
                        is_ext     = 1'b1;
                        state_next = IDLE;
                    end
                end
                // Whatever follows 0xF0 is the released key, even 0xE0/0xF0.
                BRK, EXT_BRK: begin
                    is_break   = 1'b1;
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign parse_state = state;

    always_comb begin
        is_digit = 1'b1;
        digit    = 4'd0;
        case (code)
            8'h45: digit = 4'd0;
            8'h16: digit = 4'd1;
            8'h1E: digit = 4'd2;
            8'h26: digit = 4'd3;
            8'h25: digit = 4'd4;
            8'h2E: digit = 4'd5;
            8'h36: digit = 4'd6;
            8'h3D: digit = 4'd7;
            8'h3E: digit = 4'd8;
            8'h46: digit = 4'd9;
            default: is_digit = 1'b0;
        endcase
    end

    // Any make code (digit or not, extended or not) becomes the tracked key;
    // only a break of that same byte releases it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_make <= 8'h00;
            held      <= 1'b0;
        end else if (is_make) begin
            last_make <= code;
            held      <= 1'b1;
        end else if (is_break && (code == last_make)) begin
            held <= 1'b0;
        end
    end

    assign repeat_hit = !REPEAT_EN && held && (code == last_make);
    assign push = is_make && is_digit && (!is_ext || ACCEPT_EXT) && !repeat_hit;

    // ---------------- FIFO ----------------
    assign dout_valid = (level != '0);
    assign pop        = dout_valid && dout_ready;
    assign full       = (level == LEVEL_FULL);
    // When full, a write is only possible because the pop frees the head slot
    // in the same edge (wr_ptr == rd_ptr then).
    assign wr_en      = push && (!full || pop);
    assign dout       = dout_valid ? mem[rd_ptr] : 4'd0;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= digit;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            // Pointers are AW bits wide, so they wrap modulo DEPTH naturally.
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
            overflow <= push && full && !pop;
        end
    end

endmodule

// File: tb/tb_scancode_digit_fifo.sv
// Testbench for scancode_digit_fifo.
// Two instances share one input stream:
//   dut     default parameters
//   alt     REPEAT_EN=1, ACCEPT_EXT=1
// Expected digits are queued per instance when a byte is driven.
// A negedge monitor pops and compares them whenever a FIFO pop will occur
// at the following rising edge.
module tb_scancode_digit_fifo;

    logic       clk;
    logic       resetn;
    logic [7:0] code;
    logic       code_valid;
    logic       dout_ready;

    logic [3:0] dout;
    logic       dout_valid;
    logic [3:0] level;
    logic       overflow;
    logic [1:0] parse_state;

    logic [3:0] alt_dout;
    logic       alt_dout_valid;
    logic [3:0] alt_level;
    logic       alt_overflow;
    logic [1:0] alt_parse_state;

    int checks   = 0;
    int failures = 0;
    int ov_cnt   = 0;
    int alt_ov_cnt = 0;

    logic [3:0] exp_q[$];
    logic [3:0] alt_q[$];

    logic [7:0] make_tab [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                                  8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

    scancode_digit_fifo #(.DEPTH(8), .REPEAT_EN(1'b0), .ACCEPT_EXT(1'b0)) dut (
        .clk(clk), .resetn(resetn), .code(code), .code_valid(code_valid),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .level(level), .overflow(overflow), .parse_state(parse_state)
    );

    scancode_digit_fifo #(.DEPTH(8), .REPEAT_EN(1'b1), .ACCEPT_EXT(1'b1)) alt (
        .clk(clk), .resetn(resetn), .code(code), .code_valid(code_valid),
        .dout(alt_dout), .dout_valid(alt_dout_valid), .dout_ready(dout_ready),
        .level(alt_level), .overflow(alt_overflow), .parse_state(alt_parse_state)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change at posedge+1, so values seen here are the ones the next
    // rising edge will act on.
    always @(negedge clk) begin
        if (resetn === 1'b1) begin
            if (dout_valid && dout_ready) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    failures++;
                    $error("FAIL dut_unexpected_pop observed=%0h expected=none", dout);
                end
                if (exp_q.size() != 0) check("dut_pop", 8'(dout), 8'(exp_q.pop_front()));
            end
            if (alt_dout_valid && dout_ready) begin
                checks++;
                assert (alt_q.size() != 0) else begin
                    failures++;
                    $error("FAIL alt_unexpected_pop observed=%0h expected=none", alt_dout);
                end
                if (alt_q.size() != 0) check("alt_pop", 8'(alt_dout), 8'(alt_q.pop_front()));
            end
            if (overflow)     ov_cnt++;
            if (alt_overflow) alt_ov_cnt++;
        end
    end

    // ---------------- drivers ----------------
    // All drivers start and end at posedge+1.
    task automatic send_byte(input logic [7:0] b, input bit exp_dut, input bit exp_alt,
                             input logic [3:0] d);
        code       = b;
        code_valid = 1'b1;
        if (exp_dut) exp_q.push_back(d);
        if (exp_alt) alt_q.push_back(d);
        @(posedge clk);
        #1;
        code_valid = 1'b0;
        code       = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input int n);
        dout_ready = 1'b1;
        idle(n);
        dout_ready = 1'b0;
        check("dut_q_drained", 8'(exp_q.size()), 8'd0);
        check("alt_q_drained", 8'(alt_q.size()), 8'd0);
        check("dut_empty_after_drain", 8'(dout_valid), 8'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        resetn     = 1'b0;
        code       = 8'h00;
        code_valid = 1'b0;
        dout_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_dout_valid", 8'(dout_valid), 8'd0);
        check("rst_level", 8'(level), 8'd0);
        check("rst_dout", 8'(dout), 8'd0);
        check("rst_overflow", 8'(overflow), 8'd0);
        check("rst_state", 8'(parse_state), 8'd0);
        resetn = 1'b1;
        idle(1);

        // make/break pairs for 1 and 2, consumer stalled
        send_byte(8'h16, 1, 1, 4'd1);
        send_byte(8'hF0, 0, 0, 4'd0);
        send_byte(8'h16, 0, 0, 4'd0);
        send_byte(8'h1E, 1, 1, 4'd2);
        send_byte(8'hF0, 0, 0, 4'd0);
        send_byte(8'h1E, 0, 0, 4'd0);
        check("pairs_level", 8'(level), 8'd2);
        check("pairs_head", 8'(dout), 8'd1);
        drain(2);
        check("pairs_level_end", 8'(level), 8'd0);

        // typematic repeats: dut suppresses, alt keeps them
        send_byte(8'h45, 1, 1, 4'd0);
        send_byte(8'h45, 0, 1, 4'd0);
        send_byte(8'h45, 0, 1, 4'd0);
        send_byte(8'hF0, 0, 0, 4'd0);
        send_byte(8'h45, 0, 0, 4'd0);
        send_byte(8'h45, 1, 1, 4'd0);
        check("repeat_dut_level", 8'(level), 8'd2);
        check("repeat_alt_level", 8'(alt_level), 8'd4);
        drain(5);

        // extended digit: dut drops it, alt decodes it
        send_byte(8'hE0, 0, 0, 4'd0);
        send_byte(8'h46, 0, 1, 4'd9);
        check("ext_state_idle", 8'(parse_state), 8'd0);
        send_byte(8'hE0, 0, 0, 4'd0);
        send_byte(8'hF0, 0, 0, 4'd0);
        check("ext_brk_state", 8'(parse_state), 8'd3);
        send_byte(8'h46, 0, 0, 4'd0);
        send_byte(8'h46, 1, 1, 4'd9);
        check("ext_dut_level", 8'(level), 8'd1);
        check("ext_alt_level", 8'(alt_level), 8'd2);
        drain(3);

        // overfill: digits 0..9 into an 8-deep FIFO
        ov_cnt     = 0;
        alt_ov_cnt = 0;
        for (int d = 0; d < 10; d++) begin
            send_byte(make_tab[d], d < 8, d < 8, 4'(d));
            if (d >= 8) check("ovf_pulse", 8'(overflow), 8'd1);
            send_byte(8'hF0, 0, 0, 4'd0);
            if (d >= 8) check("ovf_one_cycle", 8'(overflow), 8'd0);
            send_byte(make_tab[d], 0, 0, 4'd0);
        end
        check("full_level", 8'(level), 8'd8);
        check("ovf_count_dut", 8'(ov_cnt), 8'd2);
        check("ovf_count_alt", 8'(alt_ov_cnt), 8'd2);
        drain(8);

        // full FIFO with push and pop on the same edge
        for (int d = 0; d < 8; d++) begin
            send_byte(make_tab[d], 1, 1, 4'(d));
            send_byte(8'hF0, 0, 0, 4'd0);
            send_byte(make_tab[d], 0, 0, 4'd0);
        end
        check("refill_level", 8'(level), 8'd8);
        ov_cnt     = 0;
        dout_ready = 1'b1;
        send_byte(8'h3D, 1, 1, 4'd7);
        check("pushpop_level", 8'(level), 8'd8);
        check("pushpop_no_ovf", 8'(overflow), 8'd0);
        idle(7);
        check("last_level", 8'(level), 8'd1);
        check("last_head", 8'(dout), 8'd7);
        idle(1);
        dout_ready = 1'b0;
        check("pushpop_ovf_count", 8'(ov_cnt), 8'd0);
        check("pushpop_q_drained", 8'(exp_q.size()), 8'd0);
        check("pushpop_empty", 8'(level), 8'd0);

        // reset in the middle of a break prefix, with data queued
        send_byte(8'h16, 1, 1, 4'd1);
        send_byte(8'hF0, 0, 0, 4'd0);
        #2;
        resetn = 1'b0;
        #1;
        exp_q.delete();
        alt_q.delete();
        check("midrst_dout_valid", 8'(dout_valid), 8'd0);
        check("midrst_level", 8'(level), 8'd0);
        check("midrst_dout", 8'(dout), 8'd0);
        check("midrst_state", 8'(parse_state), 8'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        send_byte(8'h26, 1, 1, 4'd3);
        check("post_rst_dout", 8'(dout), 8'd3);
        check("post_rst_level", 8'(level), 8'd1);
        check("post_rst_valid", 8'(dout_valid), 8'd1);
        drain(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/scancode_digit_fifo.md
SCANCODE_DIGIT_FIFO -- requirements
Module: scancode_digit_fifo

Interface
REQ-001 Parameter DEPTH, default 8, meaning FIFO entries; SHALL be a power of two, 2..64.
REQ-002 Parameter REPEAT_EN, default 0, meaning 1 = typematic repeats pushed, 0 = repeats suppressed.
REQ-003 Parameter ACCEPT_EXT, default 0, meaning 1 = digit codes after an 0xE0 prefix are decoded, 0 = dropped.
REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 resetn  in  1  reset, asynchronous, active-low.
REQ-006 code  in  8  PS/2 set-2 scancode byte.
REQ-007 code_valid  in  1  code is sampled on a clk edge only when high.
REQ-008 dout  out  4  FIFO head digit, 0..9.
REQ-009 dout_valid  out  1  FIFO not empty.
REQ-010 dout_ready  in  1  consumer accepts dout when dout_valid and dout_ready are both high at a clk edge.
REQ-011 level  out  clog2(DEPTH)+1  current FIFO occupancy.
REQ-012 overflow  out  1  one-cycle pulse when a decoded digit is dropped because the FIFO is full.

Function
REQ-013 Digit map SHALL be: 0x45=0, 0x16=1, 0x1E=2, 0x26=3, 0x25=4, 0x2E=5, 0x36=6, 0x3D=7, 0x3E=8, 0x46=9; every other byte is non-digit.
REQ-014 Parser FSM states SHALL be IDLE, EXT, BRK, EXT_BRK; state changes only on edges with code_valid=1.
REQ-015 IDLE: 0xF0 -> BRK; 0xE0 -> EXT; any other byte is a make code, stays IDLE.
REQ-016 EXT: 0xF0 -> EXT_BRK; 0xE0 -> EXT; any other byte is an extended make code -> IDLE.
REQ-017 BRK: any byte, including 0xE0/0xF0, is a break code -> IDLE; EXT_BRK: any byte -> IDLE; break codes SHALL never push.
REQ-018 Make code in IDLE that maps to a digit SHALL push, subject to REQ-020; extended make digits push only when ACCEPT_EXT=1, else discarded.
REQ-019 Repeat tracking: every make code (IDLE or EXT) SHALL load last_make (8 bits) and set held=1; a break code equal to last_make SHALL clear held; other break codes leave held unchanged.
REQ-020 REPEAT_EN=0: a make code equal to last_make while held=1 SHALL NOT push; REPEAT_EN=1: no suppression.
REQ-021 Push latency: byte sampled at edge N SHALL be visible at dout/level after edge N (one cycle).
REQ-022 FIFO SHALL be first-in first-out, level increments on push-only, decrements on pop-only, unchanged on push+pop.
REQ-023 dout SHALL be 0 while empty; dout_valid = (level != 0); dout_ready while empty SHALL be ignored.
REQ-024 Full (level=DEPTH) with push and no pop: digit dropped, contents unchanged, overflow=1 for exactly the next cycle.
REQ-025 Full with simultaneous push and pop: both SHALL occur, level stays DEPTH, no overflow.
REQ-026 Empty with push and dout_ready=1: no bypass; pushed digit appears at dout after the edge, level=1.
REQ-027 Read/write pointers SHALL wrap modulo DEPTH with no lost or duplicated entries.
REQ-028 code_valid=0 SHALL leave FSM, last_make, held and pushes unaffected; pops still occur.

Reset
REQ-029 resetn low SHALL immediately force: FSM=IDLE, held=0, last_make=0x00, level=0, pointers=0, dout=0, dout_valid=0, overflow=0.
REQ-030 Reset mid-sequence (e.g. after 0xF0 or 0xE0) SHALL discard the pending prefix and all FIFO contents; the first byte after release is parsed from IDLE.

Verification
REQ-031 Bytes 0x16,0xF0,0x16,0x1E,0xF0,0x1E with dout_ready=0 -> level=2, dout=1; pop twice -> 1 then 2, dout_valid=0.
REQ-032 REPEAT_EN=0: 0x45,0x45,0x45,0xF0,0x45,0x45 -> exactly two 0s pushed; REPEAT_EN=1 same stimulus -> four 0s pushed.
REQ-033 ACCEPT_EXT=0: 0xE0,0x46,0xE0,0xF0,0x46,0x46 -> only one 9 pushed; ACCEPT_EXT=1 -> two 9s pushed.
REQ-034 DEPTH=8, dout_ready=0, push digits 0..9 via distinct make/break pairs -> level=8, overflow pulses twice, pops return 0..7.
REQ-035 Full FIFO, dout_ready=1 held, push 0x3D -> level stays 8, no overflow, 0x3D's digit 7 emerges last after 8 pops.
REQ-036 Send 0xF0, assert resetn=0 mid-cycle, release, send 0x26 -> immediate dout_valid=0 during reset, then dout=3, level=1.
